// File: rtl/i2s_rx_sampler.sv
// I2S (Philips) receiver: oversamples BCLK/LRCLK/SDATA in the clk domain, deserialises
// MSB-first stereo words and presents left/right pairs on a valid/ready handshake.
module i2s_rx_sampler #(
  parameter int unsigned BITSIZE     = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               bclk,
  input  logic               lrclk,
  input  logic               sdata,
  output logic [BITSIZE-1:0] left_chan,
  output logic [BITSIZE-1:0] right_chan,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               overrun,
  output logic               frame_err
);

  localparam int unsigned CntW = $clog2(BITSIZE + 1);

  typedef enum logic [1:0] {StSync, StShift, StPad} state_e;

  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lrclk_sync_q;
  logic [SYNC_STAGES-1:0] sdata_sync_q;
  logic                   bclk_prev_q;
  logic                   lr_prev_q;

  state_e                 state_q;
  logic                   chan_q;
  logic [CntW-1:0]        bitcnt_q;
  logic [BITSIZE-1:0]     shreg_q;
  logic [BITSIZE-1:0]     left_hold_q;
  logic [BITSIZE-1:0]     right_hold_q;
  logic                   left_ok_q;
  logic                   pair_load_q;

  logic                   bclk_s;
  logic                   lrclk_s;
  logic                   sdata_s;
  logic                   rise_evt;
  logic                   lr_edge;
  logic [BITSIZE-1:0]     shift_word;
  logic                   word_done;
  logic                   word_short;

  // Identical chains on all three inputs keep their relative alignment intact.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bclk_sync_q  <= '0;
      lrclk_sync_q <= '0;
      sdata_sync_q <= '0;
      bclk_prev_q  <= 1'b0;
    end else begin
      bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
      lrclk_sync_q <= {lrclk_sync_q[SYNC_STAGES-2:0], lrclk};
      sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata};
      bclk_prev_q  <= bclk_sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    bclk_s     = bclk_sync_q[SYNC_STAGES-1];
    lrclk_s    = lrclk_sync_q[SYNC_STAGES-1];
    sdata_s    = sdata_sync_q[SYNC_STAGES-1];
    rise_evt   = bclk_s & ~bclk_prev_q;
    lr_edge    = rise_evt & (lrclk_s != lr_prev_q);
    shift_word = {shreg_q[BITSIZE-2:0], sdata_s};
    // Holding BITSIZE-1 bits in SHIFT: this rise supplies the last bit, whether it is a
    // plain shift or the delayed LSB arriving on the LR edge.
    word_done  = rise_evt && (state_q == StShift) && (bitcnt_q == CntW'(BITSIZE - 1));
    word_short = lr_edge && (state_q != StSync) && (bitcnt_q < CntW'(BITSIZE - 1));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StSync;
      chan_q       <= 1'b0;
      bitcnt_q     <= '0;
      shreg_q      <= '0;
      left_hold_q  <= '0;
      right_hold_q <= '0;
      left_ok_q    <= 1'b0;
      pair_load_q  <= 1'b0;
      lr_prev_q    <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      pair_load_q <= 1'b0;
      if (rise_evt) begin
        lr_prev_q <= lrclk_s;
        unique case (state_q)
          StSync: begin
            if (lr_edge && !lrclk_s) begin
              state_q  <= StShift;
              chan_q   <= 1'b0;
              bitcnt_q <= '0;
              shreg_q  <= '0;
            end
          end
          StShift, StPad: begin
            if (lr_edge) begin
              state_q  <= StShift;
              chan_q   <= lrclk_s;
              bitcnt_q <= '0;
              shreg_q  <= '0;
            end else if (state_q == StShift) begin
              shreg_q  <= shift_word;
              bitcnt_q <= bitcnt_q + CntW'(1);
              if (word_done) begin
                state_q <= StPad;
              end
            end
          end
          default: state_q <= StSync;
        endcase

        if (word_done) begin
          if (!chan_q) begin
            left_hold_q <= shift_word;
            left_ok_q   <= 1'b1;
          end else begin
            if (left_ok_q) begin
              right_hold_q <= shift_word;
              pair_load_q  <= 1'b1;
            end
            left_ok_q <= 1'b0;
          end
        end

        if (word_short) begin
          frame_err <= 1'b1;
          left_ok_q <= 1'b0;
        end
      end
    end
  end

  // A load always wins over acceptance: the new pair replaces the accepted one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      left_chan    <= '0;
      right_chan   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (pair_load_q) begin
        left_chan    <= left_hold_q;
        right_chan   <= right_hold_q;
        sample_valid <= 1'b1;
        overrun      <= sample_valid & ~sample_ready;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_sampler.sv
// Directed bench for i2s_rx_sampler: drives Philips-format frames with a one-bit data delay
// and checks pairs, latency, overrun, frame errors and reset behaviour.
`timescale 1ns/1ps
module tb_i2s_rx_sampler;

  localparam int unsigned BITSIZE     = 16;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int          HalfBclk    = 162;  // even: bclk edges never meet odd-time clk rises

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               bclk = 1'b0;
  logic               lrclk = 1'b0;
  logic               sdata = 1'b0;
  logic               sample_ready = 1'b0;
  logic [BITSIZE-1:0] left_chan;
  logic [BITSIZE-1:0] right_chan;
  logic               sample_valid;
  logic               overrun;
  logic               frame_err;

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_ferr = 0;
  int   n_ovr = 0;
  int   n_vrise = 0;
  logic valid_prev = 1'b0;
  logic prev_bit = 1'b0;
  int   lat;

  i2s_rx_sampler #(
    .BITSIZE     (BITSIZE),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .left_chan    (left_chan),
    .right_chan   (right_chan),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .frame_err    (frame_err)
  );

  always #41 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (sample_valid && !valid_prev) n_vrise++;
    valid_prev = sample_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One BCLK period: data and LR change on the falling edge, sampled on the rise.
  task automatic bit_cycle(input logic lr, input logic d);
    bclk = 1'b0;
    lrclk = lr;
    sdata = d;
    #HalfBclk;
    bclk = 1'b1;
    #HalfBclk;
  endtask

  // Each slot bit appears one BCLK late, so the slot's first rise carries the previous LSB.
  task automatic send_slot(input logic ch, input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bit_cycle(ch, prev_bit);
      prev_bit = w[i];
    end
  endtask

  task automatic send_frame16(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, {16'h0, l}, 16);
    send_slot(1'b1, {16'h0, r}, 16);
  endtask

  task automatic lead_in();
    send_slot(1'b1, 32'hF, 4);
  endtask

  // Final rise with LR low: delivers the last right LSB.
  task automatic flush_start();
    bclk = 1'b0;
    lrclk = 1'b0;
    sdata = prev_bit;
    #HalfBclk;
    bclk = 1'b1;
    prev_bit = 1'b0;
  endtask

  task automatic flush_timed(output int clks);
    logic seen;
    seen = 1'b0;
    clks = 0;
    flush_start();
    while (!seen && clks < 12) begin
      @(posedge clk);
      clks++;
      #1;
      seen = sample_valid;
    end
    bclk = 1'b0;
  endtask

  task automatic flush_rise();
    flush_start();
    #HalfBclk;
    bclk = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bclk = 1'b0;
    lrclk = 1'b0;
    sdata = 1'b0;
    prev_bit = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    n_ferr = 0;
    n_ovr = 0;
    n_vrise = 0;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_left", 32'(left_chan), 32'h0);
    check_eq("rst_right", 32'(right_chan), 32'h0);
    check_eq("rst_valid", 32'(sample_valid), 32'h0);
    check_eq("rst_overrun", 32'(overrun), 32'h0);
    check_eq("rst_frame_err", 32'(frame_err), 32'h0);

    // 1: 16-bit slots, ready high, three frames
    do_reset();
    sample_ready = 1'b1;
    lead_in();
    repeat (3) send_frame16(16'hA5C3, 16'h1234);
    flush_timed(lat);
    check_eq("t1_latency", 32'(lat), 32'(SYNC_STAGES + 2));
    repeat (4) @(negedge clk);
    check_eq("t1_pairs", 32'(n_vrise), 32'd3);
    check_eq("t1_left", 32'(left_chan), 32'hA5C3);
    check_eq("t1_right", 32'(right_chan), 32'h1234);
    check_eq("t1_valid_dropped", 32'(sample_valid), 32'h0);
    check_eq("t1_frame_err", 32'(n_ferr), 32'd0);
    check_eq("t1_overrun", 32'(n_ovr), 32'd0);

    // 2: 32-bit slots, upper BITSIZE bits kept
    do_reset();
    lead_in();
    send_slot(1'b0, 32'h8001_FFFF, 32);
    send_slot(1'b1, 32'h7FFE_0000, 32);
    flush_rise();
    repeat (6) @(negedge clk);
    check_eq("t2_pairs", 32'(n_vrise), 32'd1);
    check_eq("t2_left", 32'(left_chan), 32'h8001);
    check_eq("t2_right", 32'(right_chan), 32'h7FFE);
    check_eq("t2_frame_err", 32'(n_ferr), 32'd0);

    // 3: ready low across three pairs
    do_reset();
    sample_ready = 1'b0;
    lead_in();
    send_frame16(16'h1111, 16'hEEEE);
    send_frame16(16'h2222, 16'hDDDD);
    send_frame16(16'h3333, 16'hCCCC);
    flush_rise();
    repeat (6) @(negedge clk);
    check_eq("t3_overruns", 32'(n_ovr), 32'd2);
    check_eq("t3_valid_held", 32'(sample_valid), 32'h1);
    check_eq("t3_left", 32'(left_chan), 32'h3333);
    check_eq("t3_right", 32'(right_chan), 32'hCCCC);
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    check_eq("t3_valid_fall", 32'(sample_valid), 32'h0);
    check_eq("t3_left_hold", 32'(left_chan), 32'h3333);

    // 4: left slot truncated to 10 BCLKs
    do_reset();
    sample_ready = 1'b1;
    lead_in();
    send_slot(1'b0, 32'h2AB, 10);
    send_slot(1'b1, 32'h5A5A, 16);
    send_frame16(16'hBEEF, 16'hCAFE);
    flush_rise();
    repeat (6) @(negedge clk);
    check_eq("t4_frame_err", 32'(n_ferr), 32'd1);
    check_eq("t4_pairs", 32'(n_vrise), 32'd1);
    check_eq("t4_left", 32'(left_chan), 32'hBEEF);
    check_eq("t4_right", 32'(right_chan), 32'hCAFE);

    // 5: reset mid-right-word, release mid-left-word
    do_reset();
    sample_ready = 1'b0;
    lead_in();
    send_frame16(16'h1357, 16'h2468);
    send_slot(1'b0, 32'h9999, 16);
    send_slot(1'b1, 32'h77, 8);
    check_eq("t5_pre_valid", 32'(sample_valid), 32'h1);
    check_eq("t5_pre_left", 32'(left_chan), 32'h1357);
    resetn = 1'b0;
    #2;
    check_eq("t5_rst_left", 32'(left_chan), 32'h0);
    check_eq("t5_rst_right", 32'(right_chan), 32'h0);
    check_eq("t5_rst_valid", 32'(sample_valid), 32'h0);
    send_slot(1'b1, 32'h66, 8);
    send_slot(1'b0, 32'h15, 6);
    @(negedge clk);
    resetn = 1'b1;
    sample_ready = 1'b1;
    n_vrise = 0;
    n_ferr = 0;
    n_ovr = 0;
    send_slot(1'b0, 32'h3C3, 10);
    send_slot(1'b1, 32'h4321, 16);
    send_frame16(16'h0BAD, 16'hF00D);
    check_eq("t5_no_early_pair", 32'(n_vrise), 32'd0);
    flush_rise();
    repeat (6) @(negedge clk);
    check_eq("t5_pairs", 32'(n_vrise), 32'd1);
    check_eq("t5_left", 32'(left_chan), 32'h0BAD);
    check_eq("t5_right", 32'(right_chan), 32'hF00D);

    // 6: load in the same clk as acceptance
    do_reset();
    sample_ready = 1'b0;
    lead_in();
    send_frame16(16'h0F0F, 16'hF0F0);
    send_frame16(16'h5555, 16'hAAAA);
    flush_start();
    repeat (SYNC_STAGES + 1) @(posedge clk);
    @(negedge clk);
    check_eq("t6_old_valid", 32'(sample_valid), 32'h1);
    check_eq("t6_old_left", 32'(left_chan), 32'h0F0F);
    sample_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t6_valid_kept", 32'(sample_valid), 32'h1);
    check_eq("t6_new_left", 32'(left_chan), 32'h5555);
    check_eq("t6_new_right", 32'(right_chan), 32'hAAAA);
    check_eq("t6_no_overrun", 32'(overrun), 32'h0);
    @(posedge clk);
    #1;
    check_eq("t6_valid_fall", 32'(sample_valid), 32'h0);
    sample_ready = 1'b0;
    bclk = 1'b0;
    @(negedge clk);
    check_eq("t6_overrun_count", 32'(n_ovr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
